// File: rtl/intra4x4_mode_decision_if.sv
// rtl/intra4x4_mode_decision_if.sv - feeder/selector bundle for the intra 4x4 mode decision
interface intra4x4_mode_decision_if #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 12
);
  logic                 start;
  logic [16*PIX_W-1:0]  orig;
  logic                 pred_valid;
  logic                 pred_ready;
  logic [3:0]           pred_mode;
  logic                 pred_last;
  logic [16*PIX_W-1:0]  pred;
  logic                 busy;
  logic                 done;
  logic [3:0]           best_mode;
  logic [SAD_W-1:0]     best_sad;

  // Feeder side: supplies the original block and prediction beats
  modport master (
    output start, orig, pred_valid, pred_mode, pred_last, pred,
    input  pred_ready, busy, done, best_mode, best_sad
  );

  // Selector side
  modport slave (
    input  start, orig, pred_valid, pred_mode, pred_last, pred,
    output pred_ready, busy, done, best_mode, best_sad
  );
endinterface

// File: rtl/intra4x4_mode_decision.sv
// rtl/intra4x4_mode_decision.sv - three-stage SAD pipeline picking the cheapest intra 4x4 mode
module intra4x4_mode_decision #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  intra4x4_mode_decision_if.slave bus
);
  localparam int ROW_W = PIX_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               r_state;
  logic [16*PIX_W-1:0]  r_orig;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic [3:0]           r_best_mode;
  logic [SAD_W-1:0]     r_best_sad;

  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic [3:0]           r_s1_mode;
  logic [ROW_W-1:0]     r_s1_row [4];

  logic                 r_s2_valid;
  logic                 r_s2_last;
  logic [3:0]           r_s2_mode;
  logic [SAD_W-1:0]     r_s2_sad;

  logic                 w_accept;
  logic                 w_update;
  logic [ROW_W-1:0]     w_row [4];

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_accept = bus.pred_valid && r_ready;
  // Invalid mode numbers flow through but can never win; ties keep the earlier mode
  assign w_update = (r_state != IDLE) && r_s2_valid && (r_s2_mode <= 4'd8) &&
                    (r_s2_sad < r_best_sad);

  // Per-row SAD of the incoming beat against the latched original
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_row[r] = '0;
      for (int c = 0; c < 4; c++) begin
        w_row[r] = w_row[r] + ROW_W'(absdiff(r_orig[PIX_W*(4*r+c) +: PIX_W],
                                             bus.pred[PIX_W*(4*r+c) +: PIX_W]));
      end
    end
  end

  // S1 registers row SADs, S2 registers the block total
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= '0;
      for (int r = 0; r < 4; r++) r_s1_row[r] <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_mode  <= '0;
      r_s2_sad   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_last <= bus.pred_last;
        r_s1_mode <= bus.pred_mode;
        for (int r = 0; r < 4; r++) r_s1_row[r] <= w_row[r];
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_last <= r_s1_last;
        r_s2_mode <= r_s1_mode;
        r_s2_sad  <= SAD_W'(r_s1_row[0]) + SAD_W'(r_s1_row[1]) +
                     SAD_W'(r_s1_row[2]) + SAD_W'(r_s1_row[3]);
      end
    end
  end

  // Decision FSM with registered handshake/status outputs and best-cost tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_orig      <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_best_mode <= '0;
      r_best_sad  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_update) begin
        r_best_sad  <= r_s2_sad;
        r_best_mode <= r_s2_mode;
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_orig      <= bus.orig;
            r_best_sad  <= '1;
            r_best_mode <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_accept && bus.pred_last) begin
            r_ready <= 1'b0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_s2_valid && r_s2_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pred_ready = r_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.best_mode  = r_best_mode;
  assign bus.best_sad   = r_best_sad;
endmodule

// File: doc/intra4x4_mode_decision.md
# intra4x4_mode_decision

Sequential SAD-based mode selector for 4x4 luma intra prediction. It sits directly downstream of the nine registered 4x4 predictor blocks (vertical through horizontal-up). An external feeder presents one 16-pixel prediction per beat over a valid/ready handshake. The block computes the sum of absolute differences against the latched original block, tracks the lowest-cost mode, and reports the winner when the last beat retires.

## Interface
- PIX_W, 8, bits per luma sample
- SAD_W, 12, SAD width; must be ≥ PIX_W+4
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state when low
- start  in  1  begin a decision; honoured only in IDLE
- orig  in  16*PIX_W  original 4x4 block, raster order; pixel k (k=0..15, a..p) at bits [PIX_W*k+PIX_W-1 : PIX_W*k]
- pred_valid  in  1  prediction beat present
- pred_ready  out  1  block accepts a beat this cycle
- pred_mode  in  4  H.264 intra 4x4 mode number of the beat (0..8)
- pred_last  in  1  final beat of this decision
- pred  in  16*PIX_W  predicted block, same packing as orig
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; best_mode/best_sad are final
- best_mode  out  4  winning mode
- best_sad  out  SAD_W  SAD of the winning mode

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1: latch orig, set best_sad=all ones (4095), set best_mode=0, go to RUN.
- RUN: pred_ready=1. A beat is accepted on an edge where pred_valid and pred_ready are both high. Accepting a beat with pred_last=1 moves the FSM to DRAIN.
- DRAIN: pred_ready=0. Wait for the last beat to leave the pipeline. At its compare edge, pulse done and return to IDLE.
- start in RUN or DRAIN is ignored. start in IDLE never accepts a beat in the same cycle, because pred_ready=0 in IDLE.
- Pipeline stage S1: four row SADs, each the sum of |orig-pred| over 4 pixels (PIX_W+2 bits, max 1020), registered together with mode, last and valid.
- Pipeline stage S2: sum of the four row SADs into SAD_W bits (max 4080, no saturation needed), registered.
- Pipeline stage S3, compare: if the beat's mode ≤ 8 and sad < best_sad (strict), replace best_sad and best_mode.
  - Ties keep the earlier-accepted mode.
  - A beat with mode > 8 is accepted and flows through the pipeline, but never updates best. Its pred_last still ends the decision.
- If every beat was invalid, done still fires with best_sad=4095 and best_mode=0.
- best_mode and best_sad hold after done until the next start.
- Absolute difference is computed unsigned (larger minus smaller). There is no overflow at any stage.

## Timing
- Reset values: pred_ready=0, busy=0, done=0, best_mode=0, best_sad=0, FSM=IDLE, all pipeline valids=0.
- Throughput is one beat per cycle with no bubbles required. pred_valid gaps are allowed and flow through as pipeline bubbles.
- Beat accepted at edge e0: row SADs registered at e0, total at e1, best updated at e2.
- For the last beat, done is registered high at e2 and low at e3. busy drops at e2 as well.
- From start edge to the first possible accept edge: 1 cycle.
- Reset asserted mid-decision: outputs take reset values immediately (asynchronously). In-flight beats are discarded and no done is produced. After release the block waits in IDLE for start.
- Beats presented while pred_ready=0 (IDLE or DRAIN) are not accepted. The feeder must hold them.

## Test plan
- Basic selection: orig all 100; beats mode0 all 90 (SAD 160), mode1 all 105 (SAD 80), mode8 all 99 with last. Expect done 2 cycles after the last accept, best_mode=8, best_sad=16.
- Tie rule: orig ramp k*10; beats mode2 and mode5 both offset +3 on every pixel (SAD 48), mode5 last. Expect best_mode=2, best_sad=48.
- Width extreme: orig all 0, a single beat mode4 all 255 with last. Expect best_sad=4080, best_mode=4.
- Handshake: valid toggling 1,0,1,1,0,1 over 4 beats. Expect every beat accepted exactly once. After the last accept pred_ready=0, and a further valid beat is held and not counted. start issued during DRAIN is ignored.
- Invalid mode: beat mode12 SAD 0, then mode3 SAD 200 with last. Expect best_mode=3, best_sad=200. A lone mode12 beat with last gives done with best_sad=4095, best_mode=0.
- Reset mid-run: assert reset after 2 beats are accepted. Expect all outputs at reset values in the same cycle and no done. A fresh start afterwards runs a normal decision correctly.
